branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised branch prediction and resolution unit for the RV32I core: a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. Sits beside the PC generator in IF, giving a same-cycle taken/target prediction for the fetch PC. Takes the resolved outcome of a branch or jump from EX, trains its tables, and raises a registered one-cycle redirect when the earlier prediction was wrong.

## Interface
- DATA_WIDTH, 32, width of PC and target addresses
- IDX_W, 6, index bits; table depth is 2**IDX_W entries
- TAG_W, 8, tag bits stored per entry
- clk  in  1  core clock
- rst  in  1  reset; synchronous and active-high
- bp_flush  in  1  one-cycle pulse that invalidates all entries (fence.i)
- bp_ready  out  1  high when tables are initialised; predictions are valid
- pred_pc  in  DATA_WIDTH  fetch PC to predict
- pred_hit  out  1  valid entry with matching tag
- pred_taken  out  1  predicted taken
- pred_target  out  DATA_WIDTH  predicted target; 0 when pred_taken=0
- upd_valid  in  1  resolved control-transfer instruction present in EX
- upd_cond  in  1  conditional branch
- upd_uncond  in  1  JAL/JALR
- upd_pc  in  DATA_WIDTH  PC of the resolved instruction
- upd_taken  in  1  actual outcome
- upd_target  in  DATA_WIDTH  actual target
- upd_pred_taken  in  1  prediction carried down the pipe
- upd_pred_target  in  DATA_WIDTH  predicted target carried down the pipe
- mispredict  out  1  registered one-cycle redirect pulse
- redirect_pc  out  DATA_WIDTH  correct next PC; valid while mispredict=1

## Operation
- Index is pc[IDX_W+1:2]. Tag is pc[IDX_W+TAG_W+1:IDX_W+2].
- Each entry holds: valid, tag, target, jump flag, and a 2-bit counter (STRONG_NT=0, WEAK_NT=1, WEAK_T=2, STRONG_T=3).
- FSM states:
  - BP_INIT: clears one valid bit per cycle at init_idx, which runs 0 to 2**IDX_W-1. After the last index, moves to BP_RUN.
  - BP_RUN: normal lookup and update. bp_flush moves back to BP_INIT with init_idx=0.
- While in BP_INIT: bp_ready=0, pred_hit=0, pred_taken=0, and updates are ignored. mispredict is still computed.
- Prediction (combinational):
  - pred_taken = pred_hit & (jump flag | counter[1]).
  - pred_target = entry target when pred_taken=1, else 0.
- Training, on upd_valid & (upd_cond|upd_uncond) in BP_RUN:
  - Taken and miss: allocate/overwrite the entry with valid=1, tag, target, jump flag=upd_uncond, and counter WEAK_T (STRONG_T for a jump).
  - Taken and hit: increment the counter, saturating at 3; rewrite the target.
  - Not taken and hit: decrement the counter, saturating at 0.
  - Not taken and miss: no write.
- Mispredict condition (upd_valid only): upd_taken != upd_pred_taken, or upd_taken & (upd_target != upd_pred_target).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4, computed modulo 2**DATA_WIDTH.
- Simultaneous bp_flush and update: the flush wins and the update is dropped.

## Timing
- Reset values: bp_ready=0, mispredict=0, redirect_pc=0, state=BP_INIT, init_idx=0. Counters and targets are not reset.
- After rst is released, bp_ready rises exactly 2**IDX_W cycles later.
- rst asserted mid-init restarts init_idx at 0.
- Lookup has zero latency.
- Table writes take effect at the clock edge. A lookup of the same index in the same cycle returns the old contents; there is no bypass.
- mispredict and redirect_pc are registered: they assert one cycle after the upd_valid cycle, for exactly one cycle.
- Back-to-back mispredicts produce back-to-back pulses.

## Configuration
- BP_STATS_EN defined: adds output ports stat_cf (32-bit) and stat_mispred (32-bit).
  - stat_cf counts trained updates; stat_mispred counts mispredict pulses.
  - Both wrap at 2**32, clear on rst, and are not cleared by bp_flush.
- BP_STATS_EN undefined: these ports and their counters do not exist.

## Structure
- Shared package riscv_definitions gets:
  - bhtCnt_e (the four counter states)
  - bpState_e (BP_INIT, BP_RUN)
  - btbEntry_t (valid, tag, target, jump)
- One sub-module, sat_counter2: the combinational 2-bit saturating increment/decrement.

## Test plan
- Reset release, IDX_W=6 -> bp_ready=0 for 64 cycles, then 1; pred_hit=0 throughout.
- BEQ at 0x100, taken, target 0x80, predicted not-taken -> next cycle mispredict=1, redirect_pc=0x80. A later lookup of 0x100 gives pred_taken=1, pred_target=0x80.
- Same branch resolved not-taken twice -> counter goes WEAK_T->WEAK_NT->STRONG_NT and pred_taken=0. A further not-taken update keeps STRONG_NT.
- Aliasing: 0x100 allocated, then lookup of 0x100+(1<<(IDX_W+2)) -> pred_hit=0. Taken JAL at the alias PC overwrites the entry; 0x100 then misses.
- Not-taken branch at 0x200 predicted not-taken -> mispredict=0. Taken branch predicted taken with a different target -> mispredict=1, redirect_pc = the new target.
- bp_flush during BP_RUN, with an update in the same cycle -> the update is dropped and bp_ready=0 for 64 cycles. With BP_STATS_EN, the counters are unchanged by the flush.

Source files
------------

// File: rtl/riscv_definitions_pkg.sv
// ----------------------------------------------------------------------------
// riscv_definitions
//   Shared RV32I core definitions used by the branch predictor.
//   - bhtCnt_e   : 2-bit saturating direction counter states
//   - bpState_e  : predictor table-maintenance states
//   - btbEntry_t : BTB entry view (valid, tag, target, jump) at the core's
//                  default geometry (8-bit tag, 32-bit target)
// ----------------------------------------------------------------------------
package riscv_definitions;

  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } bhtCnt_e;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bpState_e;

  localparam int BTB_TAG_W    = 8;
  localparam int BTB_TARGET_W = 32;

  typedef struct packed {
    logic                    valid;
    logic [BTB_TAG_W-1:0]    tag;
    logic [BTB_TARGET_W-1:0] target;
    logic                    jump;
  } btbEntry_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// ----------------------------------------------------------------------------
// sat_counter2
//   Combinational 2-bit saturating counter step.
//   Ports:
//     cnt      in  2  current counter value (bhtCnt_e encoding)
//     inc      in  1  1 = step towards STRONG_T, 0 = step towards STRONG_NT
//     cnt_next out 2  stepped value, held at the end stops
// ----------------------------------------------------------------------------
module sat_counter2
  import riscv_definitions::*;
(
  input  logic [1:0] cnt,
  input  logic       inc,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (inc) begin
      if (cnt != STRONG_T) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != STRONG_NT) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// ----------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped BTB with 2-bit direction counters for the RV32I core.
//   Gives a zero-latency taken/target prediction for the fetch PC, trains on
//   branches/jumps resolved in EX, and raises a registered one-cycle redirect
//   when the prediction carried down the pipe turns out wrong.
//
//   Optional feature: define BP_STATS_EN to add the stat_cf / stat_mispred
//   event counters (cleared by rst only, wrap at 2**32).
//
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     bp_flush          one-cycle pulse, invalidates every entry (fence.i)
//     bp_ready          tables initialised, predictions valid
//     pred_pc           fetch PC to look up
//     pred_hit          valid entry with matching tag
//     pred_taken        predicted taken
//     pred_target       predicted target, 0 when not predicted taken
//     upd_*             resolved control-transfer info from EX
//     mispredict        registered one-cycle redirect pulse
//     redirect_pc       correct next PC while mispredict=1
//     stat_cf           (BP_STATS_EN) trained update count
//     stat_mispred      (BP_STATS_EN) mispredict pulse count
// ----------------------------------------------------------------------------
module branch_predictor
  import riscv_definitions::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 6,
  parameter int TAG_W      = 8
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bp_flush,
  output logic                  bp_ready,
  input  logic [DATA_WIDTH-1:0] pred_pc,
  output logic                  pred_hit,
  output logic                  pred_taken,
  output logic [DATA_WIDTH-1:0] pred_target,
  input  logic                  upd_valid,
  input  logic                  upd_cond,
  input  logic                  upd_uncond,
  input  logic [DATA_WIDTH-1:0] upd_pc,
  input  logic                  upd_taken,
  input  logic [DATA_WIDTH-1:0] upd_target,
  input  logic                  upd_pred_taken,
  input  logic [DATA_WIDTH-1:0] upd_pred_target,
  output logic                  mispredict,
  output logic [DATA_WIDTH-1:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0]           stat_cf,
  output logic [31:0]           stat_mispred
`endif
);

  localparam int               DEPTH    = 2**IDX_W;
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  // --------------------------------------------------------------------------
  // State and tables. Only the valid bits need clearing, so they live in
  // flops; tag/target/jump/counter are plain arrays that are never reset.
  // --------------------------------------------------------------------------
  bpState_e              state_reg, state_next;
  logic [IDX_W-1:0]      init_idx_reg, init_idx_next;
  logic [DEPTH-1:0]      valid_reg;
  logic [TAG_W-1:0]      tag_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] target_mem [DEPTH];
  logic                  jump_mem   [DEPTH];
  logic [1:0]            cnt_mem    [DEPTH];

  logic                  mispredict_reg;
  logic [DATA_WIDTH-1:0] redirect_pc_reg;

  logic                  run;
  assign run = (state_reg == BP_RUN);

  // --------------------------------------------------------------------------
  // Init / run FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= BP_INIT;
      init_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      init_idx_reg <= init_idx_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    init_idx_next = init_idx_reg;
    case (state_reg)
      BP_INIT: begin
        init_idx_next = init_idx_reg + 1'b1;
        if (init_idx_reg == IDX_LAST) begin
          state_next    = BP_RUN;
          init_idx_next = '0;
        end
      end
      BP_RUN: begin
        if (bp_flush) begin
          state_next    = BP_INIT;
          init_idx_next = '0;
        end
      end
      default: begin
        state_next    = BP_INIT;
        init_idx_next = '0;
      end
    endcase
  end

  assign bp_ready = run;

  // --------------------------------------------------------------------------
  // Lookup (zero latency; sees the table contents before any same-cycle write)
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] pred_idx;
  logic [TAG_W-1:0] pred_tag;

  assign pred_idx    = pred_pc[IDX_W+1:2];
  assign pred_tag    = pred_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign pred_hit    = run & valid_reg[pred_idx] & (tag_mem[pred_idx] == pred_tag);
  assign pred_taken  = pred_hit & (jump_mem[pred_idx] | cnt_mem[pred_idx][1]);
  assign pred_target = pred_taken ? target_mem[pred_idx] : '0;

  // The low alignment bits and the PC bits above the tag do not take part in
  // the lookup.
  logic unused_pred_bits;
  assign unused_pred_bits = ^{pred_pc[1:0], pred_pc[DATA_WIDTH-1:IDX_W+TAG_W+2]};

  // --------------------------------------------------------------------------
  // Training
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             train_en;
  logic             alloc_en;
  logic [1:0]       cnt_upd;

  assign upd_idx  = upd_pc[IDX_W+1:2];
  assign upd_tag  = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_hit  = valid_reg[upd_idx] & (tag_mem[upd_idx] == upd_tag);
  // A flush in the same cycle wins: the update is dropped.
  assign train_en = run & ~bp_flush & upd_valid & (upd_cond | upd_uncond);
  assign alloc_en = train_en & upd_taken & ~upd_hit;

  sat_counter2 u_sat_counter2 (
    .cnt      (cnt_mem[upd_idx]),
    .inc      (upd_taken),
    .cnt_next (cnt_upd)
  );

  always_ff @(posedge clk) begin
    if (!run) begin
      valid_reg[init_idx_reg] <= 1'b0;
    end else if (alloc_en) begin
      valid_reg[upd_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_en) begin
      tag_mem[upd_idx]    <= upd_tag;
      target_mem[upd_idx] <= upd_target;
      jump_mem[upd_idx]   <= upd_uncond;
      cnt_mem[upd_idx]    <= upd_uncond ? STRONG_T : WEAK_T;
    end else if (train_en && upd_hit) begin
      cnt_mem[upd_idx] <= cnt_upd;
      if (upd_taken) target_mem[upd_idx] <= upd_target;
    end
  end

  // --------------------------------------------------------------------------
  // Mispredict detection: evaluated in every state, registered for one cycle.
  // --------------------------------------------------------------------------
  logic                  mispredict_next;
  logic [DATA_WIDTH-1:0] redirect_next;

  assign mispredict_next = upd_valid &
                           ((upd_taken != upd_pred_taken) |
                            (upd_taken & (upd_target != upd_pred_target)));
  assign redirect_next   = upd_taken ? upd_target : upd_pc + DATA_WIDTH'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_reg  <= 1'b0;
      redirect_pc_reg <= '0;
    end else begin
      mispredict_reg <= mispredict_next;
      if (mispredict_next) redirect_pc_reg <= redirect_next;
    end
  end

  assign mispredict  = mispredict_reg;
  assign redirect_pc = redirect_pc_reg;

`ifdef BP_STATS_EN
  // --------------------------------------------------------------------------
  // Event counters: survive bp_flush, cleared only by rst.
  // --------------------------------------------------------------------------
  logic [31:0] stat_cf_reg;
  logic [31:0] stat_mispred_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cf_reg      <= '0;
      stat_mispred_reg <= '0;
    end else begin
      if (train_en)       stat_cf_reg      <= stat_cf_reg + 32'd1;
      if (mispredict_reg) stat_mispred_reg <= stat_mispred_reg + 32'd1;
    end
  end

  assign stat_cf      = stat_cf_reg;
  assign stat_mispred = stat_mispred_reg;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// ----------------------------------------------------------------------------
// tb_branch_predictor
//   Self-checking bench for branch_predictor (DATA_WIDTH=32, IDX_W=6, TAG_W=8).
//   Directed vector table, hand-written reset/flush sequences, and a random
//   phase checked against a table-level reference model.
// ----------------------------------------------------------------------------
module tb_branch_predictor;

  localparam int DW    = 32;
  localparam int IW    = 6;
  localparam int TW    = 8;
  localparam int DEPTH = 64;
  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bp_flush = 1'b0;
  logic          bp_ready;
  logic [DW-1:0] pred_pc = '0;
  logic          pred_hit;
  logic          pred_taken;
  logic [DW-1:0] pred_target;
  logic          upd_valid = 1'b0;
  logic          upd_cond = 1'b0;
  logic          upd_uncond = 1'b0;
  logic [DW-1:0] upd_pc = '0;
  logic          upd_taken = 1'b0;
  logic [DW-1:0] upd_target = '0;
  logic          upd_pred_taken = 1'b0;
  logic [DW-1:0] upd_pred_target = '0;
  logic          mispredict;
  logic [DW-1:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0]   stat_cf;
  logic [31:0]   stat_mispred;
`endif

  always #5 clk = ~clk;

  branch_predictor #(.DATA_WIDTH(DW), .IDX_W(IW), .TAG_W(TW)) dut (
    .clk             (clk),
    .rst             (rst),
    .bp_flush        (bp_flush),
    .bp_ready        (bp_ready),
    .pred_pc         (pred_pc),
    .pred_hit        (pred_hit),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_cond        (upd_cond),
    .upd_uncond      (upd_uncond),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc)
`ifdef BP_STATS_EN
    ,
    .stat_cf         (stat_cf),
    .stat_mispred    (stat_mispred)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: one record per table slot, counter as a plain integer.
  // --------------------------------------------------------------------------
  bit          m_valid [DEPTH];
  logic [7:0]  m_tag   [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  bit          m_jump  [DEPTH];
  int          m_cnt   [DEPTH];
  int          m_init_left = DEPTH;
  int unsigned m_cf  = 0;
  int unsigned m_mis = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc / 4) % DEPTH;
  endfunction

  function automatic logic [7:0] tag_of(input logic [31:0] pc);
    return 8'((pc / 256) % 256);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return (m_init_left == 0) && m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  task automatic m_predict(input logic [31:0] pc, output bit tk, output logic [31:0] tgt);
    int i;
    i   = idx_of(pc);
    tk  = m_hit(pc) && (m_jump[i] || m_cnt[i] >= 2);
    tgt = tk ? m_tgt[i] : 32'h0;
  endtask

  task automatic m_clear_all();
    for (int k = 0; k < DEPTH; k++) m_valid[k] = 1'b0;
  endtask

  // One clock cycle: drive, check lookup before the edge, advance the model,
  // check the registered redirect after the edge. Entered/left at posedge+1.
  task automatic do_cycle(
    input bit fl, input bit uv, input bit cond, input bit uncond,
    input logic [31:0] upc, input bit tk, input logic [31:0] tgt,
    input bit ptk, input logic [31:0] ptgt, input logic [31:0] lpc,
    output bit a_hit, output bit a_tk, output logic [31:0] a_tgt,
    output bit a_mis, output logic [31:0] a_redir);
    bit          e_hit, e_tk, e_mis, uh;
    logic [31:0] e_tgt, e_redir;
    int          ui;
    bp_flush        = fl;
    upd_valid       = uv;
    upd_cond        = cond;
    upd_uncond      = uncond;
    upd_pc          = upc;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
    pred_pc         = lpc;
    #1;
    e_hit = m_hit(lpc);
    m_predict(lpc, e_tk, e_tgt);
    a_hit = pred_hit;
    a_tk  = pred_taken;
    a_tgt = pred_target;
    chk("bp_ready",    32'(bp_ready),   32'(m_init_left == 0));
    chk("pred_hit",    32'(a_hit),      32'(e_hit));
    chk("pred_taken",  32'(a_tk),       32'(e_tk));
    chk("pred_target", a_tgt,           e_tgt);
    e_mis   = uv && ((tk != ptk) || (tk && (tgt != ptgt)));
    e_redir = tk ? tgt : upc + 32'd4;
    if (uv && (cond || uncond) && (m_init_left == 0) && !fl) begin
      m_cf++;
      ui = idx_of(upc);
      uh = m_hit(upc);
      if (tk && !uh) begin
        m_valid[ui] = 1'b1;
        m_tag[ui]   = tag_of(upc);
        m_tgt[ui]   = tgt;
        m_jump[ui]  = uncond;
        m_cnt[ui]   = uncond ? 3 : 2;
      end else if (tk) begin
        m_cnt[ui] = (m_cnt[ui] < 3) ? m_cnt[ui] + 1 : 3;
        m_tgt[ui] = tgt;
      end else if (uh) begin
        m_cnt[ui] = (m_cnt[ui] > 0) ? m_cnt[ui] - 1 : 0;
      end
    end
    if (m_init_left > 0) m_init_left--;
    else if (fl) begin
      m_init_left = DEPTH;
      m_clear_all();
    end
    if (e_mis) m_mis++;
    @(posedge clk);
    #1;
    a_mis   = mispredict;
    a_redir = redirect_pc;
    chk("mispredict", 32'(a_mis), 32'(e_mis));
    if (e_mis) chk("redirect_pc", a_redir, e_redir);
  endtask

  task automatic idle_cycle(input logic [31:0] lpc);
    bit          h, t, m;
    logic [31:0] g, r;
    do_cycle(N, N, N, N, 32'h0, N, 32'h0, N, 32'h0, lpc, h, t, g, m, r);
  endtask

  // --------------------------------------------------------------------------
  // Directed vectors (expected values worked out by hand)
  // --------------------------------------------------------------------------
  typedef struct {
    bit          fl, uv, cond, uncond;
    logic [31:0] upc;
    bit          tk;
    logic [31:0] tgt;
    bit          ptk;
    logic [31:0] ptgt;
    logic [31:0] lpc;
    bit          e_hit, e_tk;
    logic [31:0] e_tgt;
    bit          e_mis;
    logic [31:0] e_redir;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  function automatic logic [31:0] rand_pc();
    return 32'(($urandom_range(1, 3) * 256) + ($urandom_range(0, 3) * 4));
  endfunction

  initial begin
    bit          h, t, m, hit_seen, ptk, tk, cond, uncond, uv, fl;
    logic [31:0] g, r, ptgt, tgt, upc, lpc;
    int          cnt, kind;

    // ---------------- directed table ----------------
    //          fl uv co un upc            tk tgt       ptk ptgt      lpc        hit tk tgt      mis redir
    vecs[0]  = '{N, Y, Y, N, 32'h100,      Y, 32'h80,  N, 32'h0,   32'h100,  N, N, 32'h0,   Y, 32'h80};
    vecs[1]  = '{N, N, N, N, 32'h0,        N, 32'h0,   N, 32'h0,   32'h100,  Y, Y, 32'h80,  N, 32'h0};
    vecs[2]  = '{N, Y, Y, N, 32'h100,      N, 32'h0,   Y, 32'h80,  32'h100,  Y, Y, 32'h80,  Y, 32'h104};
    vecs[3]  = '{N, Y, Y, N, 32'h100,      N, 32'h0,   N, 32'h0,   32'h100,  Y, N, 32'h0,   N, 32'h0};
    vecs[4]  = '{N, Y, Y, N, 32'h100,      N, 32'h0,   N, 32'h0,   32'h100,  Y, N, 32'h0,   N, 32'h0};
    vecs[5]  = '{N, Y, Y, N, 32'h100,      Y, 32'h80,  N, 32'h0,   32'h100,  Y, N, 32'h0,   Y, 32'h80};
    vecs[6]  = '{N, N, N, N, 32'h0,        N, 32'h0,   N, 32'h0,   32'h100,  Y, N, 32'h0,   N, 32'h0};
    vecs[7]  = '{N, N, N, N, 32'h0,        N, 32'h0,   N, 32'h0,   32'h200,  N, N, 32'h0,   N, 32'h0};
    vecs[8]  = '{N, Y, N, Y, 32'h200,      Y, 32'h400, N, 32'h0,   32'h200,  N, N, 32'h0,   Y, 32'h400};
    vecs[9]  = '{N, N, N, N, 32'h0,        N, 32'h0,   N, 32'h0,   32'h200,  Y, Y, 32'h400, N, 32'h0};
    vecs[10] = '{N, N, N, N, 32'h0,        N, 32'h0,   N, 32'h0,   32'h100,  N, N, 32'h0,   N, 32'h0};
    vecs[11] = '{N, Y, Y, N, 32'h210,      N, 32'h0,   N, 32'h0,   32'h210,  N, N, 32'h0,   N, 32'h0};
    vecs[12] = '{N, N, N, N, 32'h0,        N, 32'h0,   N, 32'h0,   32'h210,  N, N, 32'h0,   N, 32'h0};
    vecs[13] = '{N, Y, Y, N, 32'h240,      Y, 32'h600, Y, 32'h500, 32'h240,  N, N, 32'h0,   Y, 32'h600};
    vecs[14] = '{N, Y, Y, N, 32'h240,      Y, 32'h600, Y, 32'h600, 32'h240,  Y, Y, 32'h600, N, 32'h0};
    vecs[15] = '{N, Y, Y, N, 32'h240,      Y, 32'h700, Y, 32'h600, 32'h240,  Y, Y, 32'h600, Y, 32'h700};
    vecs[16] = '{N, Y, Y, N, 32'h240,      N, 32'h0,   Y, 32'h700, 32'h240,  Y, Y, 32'h700, Y, 32'h244};
    vecs[17] = '{N, N, N, N, 32'h0,        N, 32'h0,   N, 32'h0,   32'h240,  Y, Y, 32'h700, N, 32'h0};
    vecs[18] = '{N, Y, Y, N, 32'hFFFFFFFC, N, 32'h0,   Y, 32'h10,  32'h0,    N, N, 32'h0,   Y, 32'h0};

    // ---------------- reset, including a restart mid-init ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bp_ready",    32'(bp_ready),   32'h0);
    chk("rst_mispredict",  32'(mispredict), 32'h0);
    chk("rst_redirect_pc", redirect_pc,     32'h0);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    pred_pc = 32'h100;
    cnt      = 0;
    hit_seen = 1'b0;
    while (!bp_ready && cnt < 200) begin
      if (pred_hit) hit_seen = 1'b1;
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("init_ready_latency", 32'(cnt), 32'd64);
    chk("init_pred_hit_seen", 32'(hit_seen), 32'h0);
    m_init_left = 0;
    m_clear_all();
    m_cf  = 0;
    m_mis = 0;
    $display("[TB] reset/init done after %0d cycles", cnt);

    // ---------------- directed table ----------------
    for (int v = 0; v < NVEC; v++) begin
      do_cycle(vecs[v].fl, vecs[v].uv, vecs[v].cond, vecs[v].uncond, vecs[v].upc,
               vecs[v].tk, vecs[v].tgt, vecs[v].ptk, vecs[v].ptgt, vecs[v].lpc,
               h, t, g, m, r);
      chk($sformatf("vec%0d_hit", v),    32'(h), 32'(vecs[v].e_hit));
      chk($sformatf("vec%0d_taken", v),  32'(t), 32'(vecs[v].e_tk));
      chk($sformatf("vec%0d_target", v), g,      vecs[v].e_tgt);
      chk($sformatf("vec%0d_mis", v),    32'(m), 32'(vecs[v].e_mis));
      if (vecs[v].e_mis) chk($sformatf("vec%0d_redirect", v), r, vecs[v].e_redir);
      $display("[TB] vec %0d: upc=%08h lpc=%08h hit=%0b taken=%0b tgt=%08h mis=%0b redir=%08h",
               v, vecs[v].upc, vecs[v].lpc, h, t, g, m, r);
    end

    // ---------------- flush with a simultaneous update ----------------
    do_cycle(Y, Y, N, Y, 32'h210, Y, 32'h900, N, 32'h0, 32'h200, h, t, g, m, r);
    chk("flush_cycle_hit", 32'(h), 32'h1);
    chk("flush_ready_low", 32'(bp_ready), 32'h0);
`ifdef BP_STATS_EN
    chk("flush_stat_cf",      stat_cf,      m_cf);
`endif
    cnt = 0;
    while (!bp_ready && cnt < 200) begin
      idle_cycle(32'h200);
      cnt++;
    end
    chk("flush_ready_latency", 32'(cnt), 32'd64);
    idle_cycle(32'h210);
    chk("flush_dropped_update", 32'(pred_hit), 32'h0);
    idle_cycle(32'h200);
    $display("[TB] flush: ready after %0d cycles", cnt);

    // ---------------- randomized against the model ----------------
    for (int n = 0; n < 400; n++) begin
      kind   = int'($urandom_range(0, 7));
      upc    = rand_pc();
      lpc    = (n % 3 == 0) ? upc : rand_pc();
      tk     = 1'($urandom_range(0, 1));
      tgt    = 32'h1000 + 32'($urandom_range(0, 3) * 16);
      cond   = (kind <= 4);
      uncond = (kind == 5 || kind == 6);
      uv     = (kind != 7) || ($urandom_range(0, 1) == 1);
      if (uncond) tk = 1'b1;
      m_predict(upc, ptk, ptgt);
      if ($urandom_range(0, 3) == 0) begin
        ptk  = 1'($urandom_range(0, 1));
        ptgt = ptk ? 32'h1000 + 32'($urandom_range(0, 3) * 16) : 32'h0;
      end
      fl = ($urandom_range(0, 79) == 0);
      do_cycle(fl, uv, cond, uncond, upc, tk, tgt, ptk, ptgt, lpc, h, t, g, m, r);
      $display("[TB] rnd %0d: fl=%0b uv=%0b c=%0b j=%0b upc=%08h tk=%0b lpc=%08h hit=%0b taken=%0b mis=%0b",
               n, fl, uv, cond, uncond, upc, tk, lpc, h, t, m);
    end
    idle_cycle(32'h0);

`ifdef BP_STATS_EN
    chk("stat_cf",      stat_cf,      m_cf);
    chk("stat_mispred", stat_mispred, m_mis);
`endif

    // ---------------- reset wins over a pending mispredict ----------------
    rst             = 1'b1;
    upd_valid       = 1'b1;
    upd_cond        = 1'b1;
    upd_taken       = 1'b1;
    upd_target      = 32'h1234;
    upd_pred_taken  = 1'b0;
    @(posedge clk);
    #1;
    chk("rst2_mispredict",  32'(mispredict), 32'h0);
    chk("rst2_redirect_pc", redirect_pc,     32'h0);
    chk("rst2_bp_ready",    32'(bp_ready),   32'h0);
`ifdef BP_STATS_EN
    chk("rst2_stat_cf",      stat_cf,      32'h0);
    chk("rst2_stat_mispred", stat_mispred, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
